demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_router.sv | 92 +++++++++
 1 files changed

// File: rtl/demux_router.sv
// 1:2 ready/valid demultiplexer with a single-word output register per branch.
// Optional per-branch output-transfer counters are enabled by defining DEMUX_ROUTER_COUNT_EN.
module demux_router #(
    parameter int dataWidth = 64,
    parameter int delay     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inValid,
    input  logic                 inSelect,
    input  logic [dataWidth-1:0] inData,
    output logic                 inReady,
    output logic                 outValid_0,
    output logic                 outValid_1,
    output logic [dataWidth-1:0] outData_0,
    output logic [dataWidth-1:0] outData_1,
    input  logic                 outReady_0,
    input  logic                 outReady_1
`ifdef DEMUX_ROUTER_COUNT_EN
    ,
    output logic [15:0]          count_0,
    output logic [15:0]          count_1
`endif
);

    logic [1:0]           w_out_ready;
    logic [1:0]           w_full;
    logic [dataWidth-1:0] w_data [2];
`ifdef DEMUX_ROUTER_COUNT_EN
    logic [15:0]          w_count [2];
`endif

    // delay only shapes simulated output timing elsewhere; cycle behaviour ignores it
    if (delay < 0) begin : g_delay_negative
    end

    assign w_out_ready = {outReady_1, outReady_0};

    // A full branch can still accept when its word leaves on the same edge
    assign inReady = ~w_full[inSelect] | w_out_ready[inSelect];

    for (genvar gi = 0; gi < 2; gi++) begin : g_branch
        localparam logic BranchSel = 1'(gi);

        logic                 w_load;
        logic                 w_drain;
        logic                 r_full;
        logic [dataWidth-1:0] r_data;

        assign w_load  = inValid & inReady & (inSelect == BranchSel);
        assign w_drain = r_full & w_out_ready[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_full <= 1'b0;
                r_data <= '0;
            end else begin
                r_full <= w_load | (r_full & ~w_drain);
                if (w_load) begin
                    r_data <= inData;
                end
            end
        end

        assign w_full[gi] = r_full;
        assign w_data[gi] = r_data;

`ifdef DEMUX_ROUTER_COUNT_EN
        logic [15:0] r_count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= '0;
            end else if (w_drain) begin
                r_count <= r_count + 16'd1;
            end
        end

        assign w_count[gi] = r_count;
`endif
    end

    assign outValid_0 = w_full[0];
    assign outValid_1 = w_full[1];
    assign outData_0  = w_data[0];
    assign outData_1  = w_data[1];
`ifdef DEMUX_ROUTER_COUNT_EN
    assign count_0    = w_count[0];
    assign count_1    = w_count[1];
`endif

endmodule
